// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid-buffered pipeline register between execute and memory stages
// Main entry drives the outputs; skid absorbs one beat so in_ready_o can be registered.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_alu_i,
  input  logic [DATA_W-1:0] in_wdata_i,
  input  logic [RD_W-1:0]   in_rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_alu_o,
  output logic [DATA_W-1:0] out_wdata_o,
  output logic [RD_W-1:0]   out_rd_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int BEAT_W = CTRL_W + 2 * DATA_W + RD_W;
  localparam int PAY_W  = BEAT_W - CTRL_W;

  logic [BEAT_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [BEAT_W-1:0] in_beat;
  logic              accept, drain;

  assign in_beat = {in_ctrl_i, in_alu_i, in_wdata_i, in_rd_i};
  assign accept  = in_valid_i && in_ready_q;
  assign drain   = main_vld_q && out_ready_i;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    stall_d    = stall_q;

    // Invalid entries keep payload but zero ctrl so a bubble never writes state.
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      main_d     = {{CTRL_W{1'b0}}, main_q[PAY_W-1:0]};
      skid_d     = {{CTRL_W{1'b0}}, skid_q[PAY_W-1:0]};
    end else if (drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
        skid_d     = {{CTRL_W{1'b0}}, skid_q[PAY_W-1:0]};
      end else if (accept) begin
        main_d = in_beat;
      end else begin
        main_vld_d = 1'b0;
        main_d     = {{CTRL_W{1'b0}}, main_q[PAY_W-1:0]};
      end
    end else if (accept) begin
      if (!main_vld_q) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_beat;
        skid_vld_d = 1'b1;
      end
    end

    if (main_vld_q && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= !skid_vld_d;
      stall_q    <= stall_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_vld_q;
  assign out_ctrl_o  = main_q[BEAT_W-1 -: CTRL_W];
  assign out_alu_o   = main_q[PAY_W-1 -: DATA_W];
  assign out_wdata_o = main_q[RD_W +: DATA_W];
  assign out_rd_o    = main_q[RD_W-1:0];
  assign occupancy_o = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 4;
  localparam int BEAT_W = CTRL_W + 2 * DATA_W + RD_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i = '0;
  logic [DATA_W-1:0] in_alu_i = '0;
  logic [DATA_W-1:0] in_wdata_i = '0;
  logic [RD_W-1:0]   in_rd_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_alu_o;
  logic [DATA_W-1:0] out_wdata_o;
  logic [RD_W-1:0]   out_rd_o;
  logic [1:0]        occupancy_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int checks = 0;
  int failures = 0;
  logic [BEAT_W-1:0] sb[$];

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_ctrl_i(in_ctrl_i), .in_alu_i(in_alu_i), .in_wdata_i(in_wdata_i), .in_rd_i(in_rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl_o), .out_alu_o(out_alu_o), .out_wdata_o(out_wdata_o), .out_rd_o(out_rd_o),
    .occupancy_o(occupancy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] w, input logic [RD_W-1:0] r);
    in_valid_i = v;
    in_ctrl_i  = c;
    in_alu_i   = a;
    in_wdata_i = w;
    in_rd_i    = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    drive_beat(1'b0, '0, '0, '0, '0);
    sb.delete();
    step();
    rst = 1'b0;
  endtask

  // Model: flush discards everything held and incoming; otherwise drains pop, accepts push.
  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid_o) check("bubble_ctrl_zero", out_ctrl_o, 0);
      if (flush_i) begin
        sb.delete();
      end else begin
        if (out_valid_o && out_ready_i) begin
          if (sb.size() == 0) check("sb_unexpected_beat", 1, 0);
          else check("sb_beat", {out_ctrl_o, out_alu_o, out_wdata_o, out_rd_o}, sb.pop_front());
        end
        if (in_valid_i && in_ready_o)
          sb.push_back({in_ctrl_i, in_alu_i, in_wdata_i, in_rd_i});
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] pt_alu[3];
    int stalled;
    pt_alu[0] = 32'h10; pt_alu[1] = 32'h20; pt_alu[2] = 32'h30;

    // Reset state, observed while rst is still held.
    rst = 1'b1;
    #3;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_occupancy", occupancy_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_out_fields", {out_ctrl_o, out_alu_o, out_wdata_o, out_rd_o}, 0);
    do_reset();

    // Pass-through.
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b1, 4'b1001, pt_alu[i], 32'h100 + i, 5'(i + 1));
      step();
      check("pt_valid", out_valid_o, 1);
      check("pt_alu", out_alu_o, pt_alu[i]);
      check("pt_ctrl", out_ctrl_o, 4'b1001);
      check("pt_occ_le1", occupancy_o <= 2'd1, 1);
    end
    drive_beat(1'b0, '0, '0, '0, '0);
    step();
    check("pt_stall", stall_cnt_o, 0);
    check("pt_sb_empty", sb.size(), 0);

    // Back-pressure.
    do_reset();
    drive_beat(1'b1, 4'b0001, 32'hA, 32'h1, 5'd3);
    step();
    drive_beat(1'b1, 4'b0010, 32'hB, 32'h2, 5'd4);
    step();
    drive_beat(1'b0, '0, '0, '0, '0);
    stalled = 1;
    check("bp_occ", occupancy_o, 2);
    check("bp_in_ready", in_ready_o, 0);
    check("bp_out_alu", out_alu_o, 32'hA);
    repeat (2) begin step(); stalled++; end
    check("bp_hold_alu", out_alu_o, 32'hA);
    out_ready_i = 1'b1;
    step();
    check("bp_second_alu", out_alu_o, 32'hB);
    step();
    check("bp_stall_cnt", stall_cnt_o, stalled);
    check("bp_drained", out_valid_o, 0);
    check("bp_sb_empty", sb.size(), 0);

    // Flush with a same-cycle incoming beat.
    do_reset();
    drive_beat(1'b1, 4'b1111, 32'h1, 32'h1, 5'd1);
    step();
    drive_beat(1'b1, 4'b1111, 32'h2, 32'h2, 5'd2);
    step();
    check("fl_occ_full", occupancy_o, 2);
    flush_i = 1'b1;
    drive_beat(1'b1, 4'b1111, 32'hEE, 32'hEE, 5'd7);
    step();
    flush_i = 1'b0;
    drive_beat(1'b0, '0, '0, '0, '0);
    check("fl_out_valid", out_valid_o, 0);
    check("fl_out_ctrl", out_ctrl_o, 0);
    check("fl_occ", occupancy_o, 0);
    out_ready_i = 1'b1;
    repeat (3) step();
    check("fl_never_emitted", out_valid_o, 0);

    // Saturation of the 4-bit stall counter.
    do_reset();
    drive_beat(1'b1, 4'b0100, 32'h77, 32'h0, 5'd9);
    step();
    drive_beat(1'b0, '0, '0, '0, '0);
    repeat (20) step();
    check("sat_stall", stall_cnt_o, 15);
    out_ready_i = 1'b1;
    step();
    check("sat_hold_after", stall_cnt_o, 15);

    // Asynchronous reset between edges while full.
    do_reset();
    drive_beat(1'b1, 4'b1000, 32'h1, 32'h1, 5'd1);
    step();
    drive_beat(1'b1, 4'b1000, 32'h2, 32'h2, 5'd2);
    step();
    drive_beat(1'b0, '0, '0, '0, '0);
    check("ar_occ_full", occupancy_o, 2);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    check("ar_out_valid", out_valid_o, 0);
    check("ar_occ", occupancy_o, 0);
    check("ar_in_ready", in_ready_o, 1);
    check("ar_out_fields", {out_ctrl_o, out_alu_o, out_wdata_o, out_rd_o}, 0);
    check("ar_stall", stall_cnt_o, 0);
    #1 rst = 1'b0;
    step();
    out_ready_i = 1'b1;
    drive_beat(1'b1, 4'b0001, 32'h55, 32'h5, 5'd5);
    step();
    drive_beat(1'b0, '0, '0, '0, '0);
    check("ar_first_alu", out_alu_o, 32'h55);
    check("ar_first_occ", occupancy_o, 1);
    step();
    check("ar_alone", out_valid_o, 0);
    check("ar_sb_empty", sb.size(), 0);

    // Random valid/ready with periodic flush.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive_beat(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, 5'($urandom));
      out_ready_i = 1'($urandom_range(0, 2) != 0);
      flush_i = (i % 37) == 36;
      step();
    end
    flush_i = 1'b0;
    drive_beat(1'b0, '0, '0, '0, '0);
    out_ready_i = 1'b1;
    repeat (4) step();
    check("rnd_sb_empty", sb.size(), 0);
    check("rnd_out_idle", out_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  DATA_W, 32, width of each of the two data fields (ALU result, memory write data)
  CTRL_W, 4, width of the control vector (RegWrite, MemtoReg, MemRead, MemWrite in the default build)
  RD_W, 5, destination-register index width
  CNT_W, 16, stall-counter width
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk, in, 1, sole clock; all state updates on its rising edge
  rst, in, 1, asynchronous active-high reset
  flush_i, in, 1, synchronous flush; discards all held and incoming beats
  in_valid_i, in, 1, upstream beat valid
  in_ready_o, out, 1, stage can accept a beat
  in_ctrl_i, in, CTRL_W, upstream control vector
  in_alu_i, in, DATA_W, upstream ALU result
  in_wdata_i, in, DATA_W, upstream memory write data
  in_rd_i, in, RD_W, upstream destination register
  out_valid_o, out, 1, downstream beat valid
  out_ready_i, in, 1, downstream accepts beat
  out_ctrl_o, out, CTRL_W, held control vector
  out_alu_o, out, DATA_W, held ALU result
  out_wdata_o, out, DATA_W, held write data
  out_rd_o, out, RD_W, held destination register
  occupancy_o, out, 2, number of held beats (0..2)
  stall_cnt_o, out, CNT_W, count of downstream back-pressure cycles
REQ-003 One clock domain; reset asynchronous, active-high, named rst.

Function
REQ-004 Storage SHALL be two entries: main (drives all out_* fields) and skid; each holds {ctrl, alu, wdata, rd} plus a valid bit.
REQ-005 Accept = in_valid_i && in_ready_o; drain = out_valid_o && out_ready_i.
REQ-006 in_ready_o SHALL be a registered signal equal to !skid.valid (no combinational path from out_ready_i).
REQ-007 out_valid_o SHALL equal main.valid; occupancy_o = main.valid + skid.valid.
REQ-008 Accept with main empty, or main draining and skid empty: beat loads into main the same edge.
REQ-009 Accept with main held (not draining): beat loads into skid.
REQ-010 Drain with skid full: skid moves into main and skid empties; in_ready_o is 0 in that cycle, so no accept can coincide.
REQ-011 Beats SHALL leave in acceptance order; no beat duplicated or lost except by flush.
REQ-012 Latency: an accepted beat SHALL appear on out_* the cycle after acceptance when the stage is empty; throughput SHALL be one beat/cycle with out_ready_i held high.
REQ-013 out_ctrl_o SHALL be all-zero whenever out_valid_o=0 (a bubble never writes registers or memory); out_alu_o/out_wdata_o/out_rd_o hold their last value when invalid.
REQ-014 flush_i=1 at an edge: both valid bits cleared, both ctrl fields zeroed, any same-cycle accept discarded; flush has priority over accept and drain.
REQ-015 stall_cnt_o SHALL increment by 1 each edge with out_valid_o=1 and out_ready_i=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-016 Inputs SHALL be ignored while rst=1.

Reset
REQ-017 On rst assertion, immediately and independent of clk: main.valid=0, skid.valid=0, out_valid_o=0, out_ctrl_o=0, out_alu_o=0, out_wdata_o=0, out_rd_o=0, occupancy_o=0, stall_cnt_o=0, in_ready_o=1.
REQ-018 Reset asserted mid-transfer SHALL drop both held beats; the first accept after deassertion loads into main.

Verification
REQ-019 Pass-through: out_ready_i=1, beats ctrl=4'b1001, alu=0x10,0x20,0x30 on consecutive cycles -> same values on out_* one cycle later each, occupancy_o<=1, stall_cnt_o=0.
REQ-020 Back-pressure: out_ready_i=0, push alu=0xA then 0xB -> occupancy_o=2, in_ready_o=0, out_alu_o=0xA; release out_ready_i -> 0xA then 0xB emitted in order, stall_cnt_o equals stalled cycles.
REQ-021 Flush: stage holds two beats with ctrl=4'b1111, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, out_ctrl_o=0, occupancy_o=0, incoming beat never emitted.
REQ-022 Saturation: CNT_W=4, out_valid_o=1, out_ready_i=0 for 20 cycles -> stall_cnt_o stops at 15.
REQ-023 Async reset: rst pulsed between clk edges with occupancy_o=2 -> outputs reach REQ-017 values before the next edge; beat alu=0x55 after release emerges alone.
REQ-024 Random valid/ready with periodic flush versus scoreboard model -> order preserved, no loss outside flush, out_ctrl_o=0 whenever out_valid_o=0.
